// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg: mnemonic codes, MIPS opcode/funct constants and encoder state types.
package mips_instr_encoder_pkg;

    typedef enum logic [4:0] {
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR,
        M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LW, M_SW, M_LUI,
        M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_J, M_JAL
    } mnem_e;

    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a, F_SLTU = 6'h2b, F_SLL  = 6'h00, F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;

    localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e;
    localparam logic [5:0] OP_SLTI = 6'h0a, OP_LW   = 6'h23, OP_SW   = 6'h2b, OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_J    = 6'h02, OP_JAL  = 6'h03;

    // Field layout class of each mnemonic; C_BAD marks unsupported codes.
    typedef enum logic [2:0] {C_BAD, C_R, C_SH, C_JR, C_I, C_LUI, C_BZ, C_J} cls_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_e;

endpackage

// File: rtl/mips_instr_encoder_pack.sv
// mips_instr_encoder_pack: combinational {mnemonic, fields} -> {32-bit MIPS word, illegal flag}.
module mips_instr_encoder_pack
    import mips_instr_encoder_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    cls_e       cls;
    logic [5:0] code;
    logic [5:0] used;

    always_comb begin
        cls  = C_BAD;
        code = 6'h00;
        case (mnem_e'(mnem))
            M_ADD:  begin cls = C_R;   code = F_ADD;   end
            M_ADDU: begin cls = C_R;   code = F_ADDU;  end
            M_SUB:  begin cls = C_R;   code = F_SUB;   end
            M_SUBU: begin cls = C_R;   code = F_SUBU;  end
            M_AND:  begin cls = C_R;   code = F_AND;   end
            M_OR:   begin cls = C_R;   code = F_OR;    end
            M_XOR:  begin cls = C_R;   code = F_XOR;   end
            M_NOR:  begin cls = C_R;   code = F_NOR;   end
            M_SLT:  begin cls = C_R;   code = F_SLT;   end
            M_SLTU: begin cls = C_R;   code = F_SLTU;  end
            M_SLL:  begin cls = C_SH;  code = F_SLL;   end
            M_SRL:  begin cls = C_SH;  code = F_SRL;   end
            M_SRA:  begin cls = C_SH;  code = F_SRA;   end
            M_SLLV: begin cls = C_R;   code = F_SLLV;  end
            M_SRLV: begin cls = C_R;   code = F_SRLV;  end
            M_SRAV: begin cls = C_R;   code = F_SRAV;  end
            M_JR:   begin cls = C_JR;  code = F_JR;    end
            M_ADDI: begin cls = C_I;   code = OP_ADDI; end
            M_ANDI: begin cls = C_I;   code = OP_ANDI; end
            M_ORI:  begin cls = C_I;   code = OP_ORI;  end
            M_XORI: begin cls = C_I;   code = OP_XORI; end
            M_SLTI: begin cls = C_I;   code = OP_SLTI; end
            M_LW:   begin cls = C_I;   code = OP_LW;   end
            M_SW:   begin cls = C_I;   code = OP_SW;   end
            M_LUI:  begin cls = C_LUI; code = OP_LUI;  end
            M_BEQ:  begin cls = C_I;   code = OP_BEQ;  end
            M_BNE:  begin cls = C_I;   code = OP_BNE;  end
            M_BLEZ: begin cls = C_BZ;  code = OP_BLEZ; end
            M_BGTZ: begin cls = C_BZ;  code = OP_BGTZ; end
            M_J:    begin cls = C_J;   code = OP_J;    end
            M_JAL:  begin cls = C_J;   code = OP_JAL;  end
            default: ;
        endcase
    end

    // Field-use mask, bit order {rs, rt, rd, shamt, imm, target}.
    assign used = cls == C_R   ? 6'b111000 :
                  cls == C_SH  ? 6'b011100 :
                  cls == C_JR  ? 6'b100000 :
                  cls == C_I   ? 6'b110010 :
                  cls == C_LUI ? 6'b010010 :
                  cls == C_BZ  ? 6'b100010 :
                  cls == C_J   ? 6'b000001 : 6'b000000;

    assign word = cls == C_R   ? {6'h00, rs, rt, rd, 5'b0, code} :
                  cls == C_SH  ? {6'h00, 5'b0, rt, rd, shamt, code} :
                  cls == C_JR  ? {6'h00, rs, 15'b0, code} :
                  cls == C_I   ? {code, rs, rt, imm} :
                  cls == C_LUI ? {code, 5'b0, rt, imm} :
                  cls == C_BZ  ? {code, rs, 5'b0, imm} :
                  cls == C_J   ? {code, target} : 32'h0000_0000;

    assign illegal = (cls == C_BAD) ||
                     |({|rs, |rt, |rd, |shamt, |imm, |target} & ~used);

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: streams instruction descriptors into consecutive imem words.
// Optional ENC_ILLEGAL_CHECK_EN adds a sticky err output and suppresses writes of illegal descriptors.
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   count
`ifdef ENC_ILLEGAL_CHECK_EN
    ,
    output logic              err
`endif
);

    state_e            state, nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       word, pk_word;
    logic              pk_ill, last_q, full_q, hs, at_top, drop;

    mips_instr_encoder_pack u_pack (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pk_word),
        .illegal (pk_ill)
    );

`ifdef ENC_ILLEGAL_CHECK_EN
    assign drop = pk_ill;
`else
    logic unused_ill;
    assign unused_ill = pk_ill;
    assign drop       = 1'b0;
`endif

    assign hs     = in_valid & in_ready;
    assign at_top = &addr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;

    // A dropped (illegal) descriptor skips WRITE but still honours in_last.
    always_comb begin
        nxt = state == S_IDLE  ? (start ? S_RUN : S_IDLE) :
              state == S_RUN   ? (!hs ? S_RUN : !drop ? S_WRITE : in_last ? S_DONE : S_RUN) :
              state == S_WRITE ? ((last_q | at_top) ? S_DONE : S_RUN) : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            cnt    <= '0;
            word   <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE && start) begin
                addr   <= base_addr;
                cnt    <= '0;
                full_q <= 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
                err    <= 1'b0;
`endif
            end
            if (hs) begin
                word   <= pk_word;
                last_q <= in_last;
`ifdef ENC_ILLEGAL_CHECK_EN
                err    <= err | pk_ill;
`endif
            end
            // The address saturates at the top word instead of wrapping.
            if (state == S_WRITE) begin
                cnt <= cnt + 1'b1;
                if (at_top) full_q <= 1'b1;
                else        addr   <= addr + 1'b1;
            end
        end
    end

    assign in_ready   = state == S_RUN;
    assign imem_we    = state == S_WRITE;
    assign imem_addr  = addr;
    assign imem_wdata = word;
    assign busy       = state != S_IDLE;
    assign done       = state == S_DONE;
    assign full       = full_q;
    assign count      = cnt;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: randomized scoreboard bench with an arithmetic MIPS encoding model.
// Honours ENC_ILLEGAL_CHECK_EN when the design is built with it.
module tb_mips_instr_encoder;
    import mips_instr_encoder_pkg::*;

    localparam int AW  = 10;
    localparam int TOP = (1 << AW) - 1;

    logic          clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
    logic [AW-1:0] base_addr = '0;
    logic [4:0]    in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          in_ready, imem_we, busy, done, full;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
`ifdef ENC_ILLEGAL_CHECK_EN
    logic          err;
    bit            exp_err;
`endif

    mips_instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .full(full), .count(count)
`ifdef ENC_ILLEGAL_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int exp_addr, exp_count, done_cnt = 0, done_base;
    bit exp_full;
    logic [AW+31:0] exp_q[$];
    logic [31:0] last_wd;

    // Layout kind per mnemonic code: 0 rs/rt/rd, 1 fixed shift, 3 JR, 4 I, 5 LUI, 6 BLEZ/BGTZ, 7 J, 8 unsupported.
    int kind_t [32] = '{0,0,0,0,0,0,0,0,0,0, 1,1,1, 0,0,0, 3, 4,4,4,4,4,4,4, 5, 4,4, 6,6, 7,7, 8};
    int code_t [32] = '{'h20,'h21,'h22,'h23,'h24,'h25,'h26,'h27,'h2a,'h2b, 'h00,'h02,'h03,
                        'h04,'h06,'h07, 'h08, 'h08,'h0c,'h0d,'h0e,'h0a,'h23,'h2b, 'h0f,
                        'h04,'h05, 'h06,'h07, 'h02,'h03, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_enc(input int m, rs, rt, rd, sh, imm, tg,
                                    output logic [31:0] w, output bit legal);
        longint v = 0;
        longint c = longint'(code_t[m]);
        bit [5:0] used = 0;
        bit [5:0] nz;
        case (kind_t[m])
            0: begin v = (longint'(rs) << 21) + (longint'(rt) << 16) + (longint'(rd) << 11) + c; used = 6'b111000; end
            1: begin v = (longint'(rt) << 16) + (longint'(rd) << 11) + sh * 64 + c; used = 6'b011100; end
            3: begin v = (longint'(rs) << 21) + c; used = 6'b100000; end
            4: begin v = (c << 26) + (longint'(rs) << 21) + (longint'(rt) << 16) + imm; used = 6'b110010; end
            5: begin v = (c << 26) + (longint'(rt) << 16) + imm; used = 6'b010010; end
            6: begin v = (c << 26) + (longint'(rs) << 21) + imm; used = 6'b100010; end
            7: begin v = (c << 26) + tg; used = 6'b000001; end
            default: v = 0;
        endcase
        nz = {rs != 0, rt != 0, rd != 0, sh != 0, imm != 0, tg != 0};
        w = v[31:0];
        legal = kind_t[m] != 8 && (nz & ~used) == 0;
    endfunction

    task automatic model_accept(input int m, rs, rt, rd, sh, imm, tg, output bit legal);
        logic [31:0] w;
        ref_enc(m, rs, rt, rd, sh, imm, tg, w, legal);
`ifndef ENC_ILLEGAL_CHECK_EN
        legal = 1;
`endif
        if (legal) begin
            exp_q.push_back({AW'(exp_addr), w});
            exp_count++;
            if (exp_addr == TOP) exp_full = 1;
            else exp_addr++;
        end
`ifdef ENC_ILLEGAL_CHECK_EN
        else exp_err = 1;
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && imem_we) begin
            last_wd = imem_wdata;
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e[AW+31:32]));
                chk("wr_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic start_s(input int b);
        @(negedge clk);
        base_addr = AW'(b);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        exp_addr = b; exp_count = 0; exp_full = 0; done_base = done_cnt;
`ifdef ENC_ILLEGAL_CHECK_EN
        exp_err = 0;
        chk("err_cleared", 64'(err), 0);
`endif
        chk("busy_after_start", 64'(busy), 1);
    endtask

    task automatic send(input int m, rs, rt, rd, sh, imm, tg, input bit last, output bit ok);
        int n = 0;
        bit legal;
        in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
        in_imm = 16'(imm); in_target = 26'(tg); in_last = last; in_valid = 1;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        ok = in_ready;
        if (ok) begin
            model_accept(m, rs, rt, rd, sh, imm, tg, legal);
            @(posedge clk);
            #1 chk("latency_we", 64'(imem_we), 64'(legal));
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic end_session();
        int n = 0;
        while ((done_cnt == done_base || busy) && n < 20) begin @(negedge clk); n++; end
        chk("done_pulses", 64'(done_cnt - done_base), 1);
        chk("idle", 64'(busy), 0);
        chk("count", 64'(count), 64'(exp_count));
        chk("full", 64'(full), 64'(exp_full));
        chk("drained", 64'(exp_q.size()), 0);
`ifdef ENC_ILLEGAL_CHECK_EN
        chk("err", 64'(err), 64'(exp_err));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int snap;
        repeat (3) @(negedge clk);
        chk("rst_we", 64'(imem_we), 0);
        chk("rst_addr", 64'(imem_addr), 0);
        chk("rst_wdata", 64'(imem_wdata), 0);
        chk("rst_flags", 64'({busy, done, full, in_ready}), 0);
        chk("rst_count", 64'(count), 0);
        rst_n = 1;

        start_s('h010);
        last_wd = '1;
        send(M_ADD, 1, 2, 3, 0, 0, 0, 1, ok);
        chk("t1_accept", 64'(ok), 1);
        end_session();
        chk("t1_word", 64'(last_wd), 64'h00221820);

        start_s('h100);
        send(M_ADDI, 0, 8, 0, 0, 5, 0, 0, ok);
        @(negedge clk); base_addr = '0; start = 1; @(posedge clk); #1 start = 0;
        send(M_LW, 29, 9, 0, 0, 4, 0, 0, ok);
        send(M_J, 0, 0, 0, 0, 0, 'h10, 1, ok);
        chk("t2_accept", 64'(ok), 1);
        end_session();
        chk("t2_last_word", 64'(last_wd), 64'h08000010);

        start_s('h020);
        in_mnem = 5'(M_SLL); in_rs = 0; in_rt = 1; in_rd = 2; in_shamt = 4;
        in_imm = 0; in_target = 0; in_last = 0; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t3_ready_toggle", 64'(in_ready), 64'(i % 2 == 0));
            if (in_ready) model_accept(M_SLL, 0, 1, 2, 4, 0, 0, ok);
            if (i == 5) in_valid = 0;
        end
        chk("t3_word", 64'(last_wd), 64'h00011100);
        send(M_SRA, 0, 3, 4, 31, 0, 0, 1, ok);
        end_session();

        start_s(TOP - 1);
        send(M_ADDI, 0, 1, 0, 0, 'h111, 0, 0, ok);
        send(M_ADDI, 0, 2, 0, 0, 'h222, 0, 0, ok);
        send(M_ADDI, 0, 3, 0, 0, 'h333, 0, 0, ok);
        chk("t4_third_refused", 64'(ok), 0);
        end_session();

        start_s('h040);
        send(M_OR, 4, 5, 6, 0, 0, 0, 0, ok);
        #1 rst_n = 0;
        #1;
        chk("t5_we_drop", 64'(imem_we), 0);
        chk("t5_busy_count", 64'({busy, count}), 0);
        exp_q.delete();
        snap = done_cnt;
        @(negedge clk); rst_n = 1;
        repeat (4) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt - snap), 0);
        chk("t5_idle", 64'(busy), 0);

        start_s('h200);
        last_wd = '1;
        send(31, 0, 0, 0, 0, 0, 0, 1, ok);
        end_session();
`ifndef ENC_ILLEGAL_CHECK_EN
        chk("t6_nop", 64'(last_wd), 0);
`else
        start_s('h201);
        send(M_JR, 31, 0, 0, 0, 0, 0, 1, ok);
        end_session();
`endif

        for (int s = 0; s < 10; s++) begin
            int n;
            n = $urandom_range(1, 6);
            start_s($urandom_range(0, 900));
            for (int k = 0; k < n; k++) begin
                bit sparse;
                int m;
                sparse = $urandom_range(0, 1) == 1;
                m = $urandom_range(0, 31);
                send(m, $urandom_range(0, 31), $urandom_range(0, 31),
                     sparse ? 0 : $urandom_range(0, 31), sparse ? 0 : $urandom_range(0, 31),
                     $urandom_range(0, 65535), sparse ? 0 : $urandom_range(0, (1 << 26) - 1),
                     k == n - 1, ok);
                chk("rand_accept", 64'(ok), 1);
            end
            end_session();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
